// File: rtl/cgra_pkg.sv
// Shared CGRA constants, including the geometry of the CGRA-local scratchpad.
package cgra_pkg;

    localparam int unsigned N_COL               = 4;
    localparam int unsigned DP_WIDTH            = 32;

    localparam int unsigned MEM_N_BANKS         = 4;
    localparam int unsigned MEM_N_BANKS_LOG2    = $clog2(MEM_N_BANKS);
    localparam int unsigned MEM_BANK_DEPTH      = 256;
    localparam int unsigned MEM_BANK_DEPTH_LOG2 = $clog2(MEM_BANK_DEPTH);

endpackage

// File: rtl/cgra_mem_bank.sv
// One scratchpad bank: round-robin winner select among candidate columns,
// single-port storage with a registered read port.
module cgra_mem_bank
    import cgra_pkg::*;
#(
    parameter int unsigned N_COL    = cgra_pkg::N_COL,
    parameter int unsigned DP_WIDTH = cgra_pkg::DP_WIDTH,
    parameter int unsigned DEPTH    = MEM_BANK_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_COL-1:0]           i_cand,
    input  logic [N_COL-1:0]           i_wen,
    input  logic [$clog2(DEPTH)-1:0]   i_row   [N_COL],
    input  logic [DP_WIDTH-1:0]        i_wdata [N_COL],
    output logic [N_COL-1:0]           o_gnt_c,
    output logic [DP_WIDTH-1:0]        o_rdata
);

    localparam int unsigned ROW_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = (N_COL > 1) ? $clog2(N_COL) : 1;

    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    w_win;
    logic                w_found;
    logic                w_fire;
    logic [ROW_W-1:0]    w_row;
    logic [DP_WIDTH-1:0] r_mem [DEPTH];
    logic [DP_WIDTH-1:0] r_rdata;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int unsigned k);
        return PTR_W'((32'(ptr) + k) % N_COL);
    endfunction

    // First candidate at or after the round-robin pointer, scanning upward.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < N_COL; k++) begin
            if (!w_found && i_cand[ptr_add(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = ptr_add(r_rr_ptr, k);
            end
        end
    end

    // Grants are suppressed while reset is held so nothing touches storage.
    assign w_fire = w_found && i_rst_n;
    assign w_row  = i_row[w_win];

    always_comb begin
        o_gnt_c = '0;
        if (w_fire) begin
            o_gnt_c[w_win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= ptr_add(w_win, 1);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_fire && !i_wen[w_win]) begin
            r_mem[w_row] <= i_wdata[w_win];
        end
        if (w_fire && i_wen[w_win]) begin
            r_rdata <= r_mem[w_row];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cgra_mem_responder.sv
// CGRA-local scratchpad: word-interleaved banks serving the per-column
// req/gnt/rvalid data ports, one-cycle read latency.
module cgra_mem_responder
    import cgra_pkg::*;
#(
    parameter int unsigned N_COL      = cgra_pkg::N_COL,
    parameter int unsigned DP_WIDTH   = cgra_pkg::DP_WIDTH,
    parameter int unsigned N_BANKS    = MEM_N_BANKS,
    parameter int unsigned BANK_DEPTH = MEM_BANK_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_COL-1:0]    data_req_i,
    input  logic [N_COL-1:0]    data_wen_i,
    input  logic [N_COL-1:0]    data_ind_i,
    input  logic [DP_WIDTH-1:0] data_add_i    [N_COL],
    input  logic [DP_WIDTH-1:0] data_wdata_i  [N_COL],
    output logic [N_COL-1:0]    data_gnt_o,
    output logic [N_COL-1:0]    data_rvalid_o,
    output logic [DP_WIDTH-1:0] data_rdata_o  [N_COL]
);

    localparam int unsigned BANK_LOG2 = $clog2(N_BANKS);
    localparam int unsigned BANK_W    = (BANK_LOG2 > 0) ? BANK_LOG2 : 1;
    localparam int unsigned ROW_W     = $clog2(BANK_DEPTH);

    logic [BANK_W-1:0]   w_bank       [N_COL];
    logic [ROW_W-1:0]    w_row        [N_COL];
    logic [N_COL-1:0]    w_cand       [N_BANKS];
    logic [N_COL-1:0]    w_bank_gnt   [N_BANKS];
    logic [DP_WIDTH-1:0] w_bank_rdata [N_BANKS];

    logic [N_COL-1:0]    r_pend;
    logic [BANK_W-1:0]   r_pend_bank  [N_COL];
    logic [DP_WIDTH-1:0] r_hold       [N_COL];

    // The indirect tag is part of the port protocol but plays no role here.
    logic w_unused_ind;
    assign w_unused_ind = ^data_ind_i;

    // Word-interleaved decode; upper address bits fall off, so addresses wrap.
    always_comb begin
        for (int unsigned c = 0; c < N_COL; c++) begin
            w_bank[c] = BANK_W'((data_add_i[c] >> 2) % N_BANKS);
            w_row[c]  = ROW_W'(data_add_i[c] >> (2 + BANK_LOG2));
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            for (int unsigned c = 0; c < N_COL; c++) begin
                w_cand[b][c] = data_req_i[c] && (32'(w_bank[c]) == b);
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        cgra_mem_bank #(
            .N_COL    (N_COL),
            .DP_WIDTH (DP_WIDTH),
            .DEPTH    (BANK_DEPTH)
        ) u_bank (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_cand  (w_cand[b]),
            .i_wen   (data_wen_i),
            .i_row   (w_row),
            .i_wdata (data_wdata_i),
            .o_gnt_c (w_bank_gnt[b]),
            .o_rdata (w_bank_rdata[b])
        );
    end

    // Each column decodes to exactly one bank, so OR-ing yields at most one grant per column.
    always_comb begin
        data_gnt_o = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            data_gnt_o = data_gnt_o | w_bank_gnt[b];
        end
    end

    // Read data comes from the bank register when pending, else the held copy.
    always_comb begin
        for (int unsigned c = 0; c < N_COL; c++) begin
            data_rdata_o[c] = r_pend[c] ? w_bank_rdata[r_pend_bank[c]] : r_hold[c];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
            for (int unsigned c = 0; c < N_COL; c++) begin
                r_pend_bank[c] <= '0;
                r_hold[c]      <= '0;
            end
        end else begin
            r_pend <= data_gnt_o & data_wen_i;
            for (int unsigned c = 0; c < N_COL; c++) begin
                r_pend_bank[c] <= w_bank[c];
                r_hold[c]      <= data_rdata_o[c];
            end
        end
    end

    assign data_rvalid_o = r_pend;

endmodule

// File: tb/tb_cgra_mem_responder.sv
// Self-checking bench for cgra_mem_responder: directed vector table, reset
// corner case and randomized traffic against a flat-memory reference model.
module tb_cgra_mem_responder;

    localparam int NC    = 4;
    localparam int WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  wen;
    logic [3:0]  ind;
    logic [31:0] add   [NC];
    logic [31:0] wdata [NC];
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata [NC];

    cgra_mem_responder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_req_i    (req),
        .data_wen_i    (wen),
        .data_ind_i    (ind),
        .data_add_i    (add),
        .data_wdata_i  (wdata),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_rdata_o  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flat word memory plus per-bank round-robin pointers.
    logic [31:0] m_mem [WORDS];
    int          m_rr  [NC];
    logic [3:0]  m_rvalid;
    logic [31:0] m_rdata [NC];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]       req;
        logic [3:0]       wen;
        logic [3:0][31:0] add;
        logic [3:0][31:0] wdata;
        logic [3:0]       gnt;
        logic [3:0]       rv;
        logic [3:0][31:0] rd;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(input logic [3:0] q, input logic [3:0] w,
                                input logic [3:0][31:0] a, input logic [3:0][31:0] d,
                                input logic [3:0] g, input logic [3:0] v,
                                input logic [3:0][31:0] r);
        vec_t t;
        t.req = q; t.wen = w; t.add = a; t.wdata = d; t.gnt = g; t.rv = v; t.rd = r;
        return t;
    endfunction

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 2) % 32'(NC));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % 32'(WORDS));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NC; b++) m_rr[b] = 0;
        for (int c = 0; c < NC; c++) m_rdata[c] = '0;
        m_rvalid = '0;
    endtask

    // One bus cycle: drive, check grants mid-cycle, then check registered outputs after the edge.
    task automatic run_cycle(input logic [3:0] q, input logic [3:0] w,
                             input logic [3:0][31:0] a, input logic [3:0][31:0] d,
                             output logic [3:0] g_act, output logic [3:0] v_act,
                             output logic [3:0][31:0] rd_act);
        logic [3:0] eg;
        req = q;
        wen = w;
        ind = 4'($urandom);
        for (int c = 0; c < NC; c++) begin
            add[c]   = a[c];
            wdata[c] = d[c];
        end
        #1;
        g_act = gnt;
        eg = '0;
        for (int b = 0; b < NC; b++) begin
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m_rr[b] + k) % NC;
                if (q[c] && bank_of(a[c]) == b) begin
                    eg[c]   = 1'b1;
                    m_rr[b] = (c + 1) % NC;
                    break;
                end
            end
        end
        chk("gnt", 32'(g_act), 32'(eg));
        m_rvalid = eg & w;
        for (int c = 0; c < NC; c++)
            if (eg[c] && w[c]) m_rdata[c] = m_mem[word_of(a[c])];
        for (int c = 0; c < NC; c++)
            if (eg[c] && !w[c]) m_mem[word_of(a[c])] = d[c];
        @(posedge clk);
        #1;
        v_act = rvalid;
        for (int c = 0; c < NC; c++) rd_act[c] = rdata[c];
        chk("rvalid", 32'(v_act), 32'(m_rvalid));
        for (int c = 0; c < NC; c++)
            chk($sformatf("rdata%0d", c), rd_act[c], m_rdata[c]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]       g, v;
        logic [3:0][31:0] rd, a, d;

        tv[0]  = mk(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, 4'h1, 4'h1,
                    {32'hA500_0030, 32'hA500_0020, 32'hA500_0010, 32'hA500_0000});
        tv[1]  = mk(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, 4'h2, 4'h2,
                    {32'hA500_0030, 32'hA500_0020, 32'hA500_0010, 32'hA500_0000});
        tv[2]  = mk(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, 4'h4, 4'h4,
                    {32'hA500_0030, 32'hA500_0020, 32'hA500_0010, 32'hA500_0000});
        tv[3]  = mk(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, 4'h8, 4'h8,
                    {32'hA500_0030, 32'hA500_0020, 32'hA500_0010, 32'hA500_0000});
        tv[4]  = mk(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, 4'h1, 4'h1,
                    {32'hA500_0030, 32'hA500_0020, 32'hA500_0010, 32'hA500_0000});
        tv[5]  = mk(4'h1, 4'h0, {32'h0, 32'h0, 32'h0, 32'h10}, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
                    4'h1, 4'h0, '0);
        tv[6]  = mk(4'h1, 4'h1, {32'h0, 32'h0, 32'h0, 32'h10}, '0, 4'h1, 4'h1,
                    {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF});
        tv[7]  = mk(4'hF, 4'hF, {32'hC, 32'h8, 32'h4, 32'h0}, '0, 4'hF, 4'hF,
                    {32'hA500_000C, 32'hA500_0008, 32'hA500_0004, 32'hA500_0000});
        tv[8]  = mk(4'h2, 4'h0, {32'h0, 32'h0, 32'h1000, 32'h0}, {32'h0, 32'h0, 32'h1234, 32'h0},
                    4'h2, 4'h0, '0);
        tv[9]  = mk(4'h4, 4'h4, {32'h0, 32'h3, 32'h0, 32'h0}, '0, 4'h4, 4'h4,
                    {32'h0, 32'h1234, 32'h0, 32'h0});
        tv[10] = mk(4'h8, 4'h0, {32'h24, 32'h0, 32'h0, 32'h0}, {32'h55AA, 32'h0, 32'h0, 32'h0},
                    4'h8, 4'h0, '0);
        tv[11] = mk(4'h2, 4'h2, {32'h0, 32'h0, 32'h24, 32'h0}, '0, 4'h2, 4'h2,
                    {32'h0, 32'h0, 32'h55AA, 32'h0});
        tv[12] = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, '0);
        tv[13] = mk(4'h3, 4'h2, {32'h0, 32'h0, 32'h14, 32'h4}, {32'h0, 32'h0, 32'h0, 32'hCAFE},
                    4'h1, 4'h0, '0);

        rst_n = 1'b0;
        req   = 4'hF;
        wen   = 4'hF;
        ind   = '0;
        for (int c = 0; c < NC; c++) begin
            add[c]   = 32'(c * 4);
            wdata[c] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata0", rdata[0], 32'h0);
        rst_n = 1'b1;

        // Fill every word with a known pattern, one bank per column per cycle.
        for (int i = 0; i < WORDS / NC; i++) begin
            for (int c = 0; c < NC; c++) begin
                a[c] = 32'((i * NC + c) * 4);
                d[c] = 32'hA500_0000 ^ a[c];
            end
            run_cycle(4'hF, 4'h0, a, d, g, v, rd);
        end

        // Reset leaves memory intact and restarts arbitration from column 0.
        req   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            run_cycle(tv[i].req, tv[i].wen, tv[i].add, tv[i].wdata, g, v, rd);
            chk($sformatf("tv%0d_gnt", i), 32'(g), 32'(tv[i].gnt));
            chk($sformatf("tv%0d_rvalid", i), 32'(v), 32'(tv[i].rv));
            for (int c = 0; c < NC; c++)
                if (tv[i].rv[c]) chk($sformatf("tv%0d_rdata%0d", i, c), rd[c], tv[i].rd[c]);
        end

        // Reset right after a read grant: the read is dropped and outputs clear.
        req    = 4'h1;
        wen    = 4'h1;
        add[0] = 32'h4;
        #1;
        chk("rst_pre_gnt", 32'(gnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt_forced", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        for (int c = 0; c < NC; c++) chk($sformatf("rst_rdata%0d", c), rdata[c], 32'h0);
        @(posedge clk);
        #1;
        chk("rst_held_rvalid", 32'(rvalid), 32'h0);
        req   = '0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);
        chk("post_rst_rdata0", rdata[0], 32'h0);
        run_cycle(4'hF, 4'hF, {32'h30, 32'h20, 32'h10, 32'h0}, '0, g, v, rd);
        chk("post_rst_rr_col0", 32'(g), 32'h1);

        // Randomized traffic; rows restricted so same-word and same-bank hits are frequent.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                a[c] = $urandom & ~32'h0000_03F0;
                d[c] = $urandom;
            end
            run_cycle(4'($urandom), 4'($urandom), a, d, g, v, rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
